tft_spi_sched: RTL and testbench
================================

TFT_SPI_SCHED -- requirements
Module: tft_spi_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 2, meaning: cycles tft_cs_n stays high between non-burst transactions (1..15).
REQ-002 Parameter CMD_PRIORITY, default 1, meaning: 1 = command port wins simultaneous requests outside a pixel burst; 0 = pixel port wins.
REQ-003 SPI_CLK  input  1  single clock; all state changes on the negedge, matching the serializer.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_data / cmd_dc  input  1/16/1  command-port word request, word, and D/C level (0 = command, 1 = parameter).
REQ-006 cmd_ready  output  1  command word accepted this cycle (cmd_valid & cmd_ready).
REQ-007 pix_valid / pix_data / pix_last  input  1/16/1  pixel-port word request, RGB565 word, and last word of the burst.
REQ-008 pix_ready  output  1  pixel word accepted this cycle.
REQ-009 word_data  output  16  word currently being shifted, MSB first.
REQ-010 bit_cnt  output  4  index of the bit on the wire; MOSI = word_data[15-bit_cnt].
REQ-011 tft_cs_n / tft_dc  output  1/1  panel chip select (active low) and data/command line.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 burst_done  output  1  one-cycle pulse after the last bit of a pix_last word.

Function
REQ-014 FSM states: IDLE, SHIFT, GAP; the block SHALL also track a burst_lock flag.
REQ-015 IDLE: tft_cs_n=1, bit_cnt=0, no ready asserted unless a request is present.
REQ-016 Grant: the block SHALL assert exactly one ready, combinationally with the winning valid, only in IDLE or in SHIFT with bit_cnt==15.
REQ-017 Arbitration with burst_lock=0: the CMD_PRIORITY winner takes simultaneous requests; a lone requester always wins.
REQ-018 Arbitration with burst_lock=1: only the pixel port SHALL be granted; cmd_valid waits.
REQ-019 burst_lock SHALL set on acceptance of a pixel word with pix_last=0 and clear on acceptance of a pix_last=1 word.
REQ-020 The accepted word and its DC SHALL load into word_data/tft_dc on the accept edge; the next cycle is bit_cnt=0, tft_cs_n=0, state SHIFT.
REQ-021 SHIFT: bit_cnt SHALL increment 0..15, one step per cycle; word_data and tft_dc SHALL be held stable for all 16 cycles.
REQ-022 At bit_cnt==15 with a grant: back-to-back load, bit_cnt wraps to 0, tft_cs_n stays low (zero-gap).
REQ-023 At bit_cnt==15 with no grant and burst_lock=1: the block SHALL stay in SHIFT, holding bit_cnt=15 and tft_cs_n=0, until pix_valid.
REQ-024 At bit_cnt==15 with no grant and burst_lock=0: go to GAP with tft_cs_n=1 for GAP_CYCLES cycles, then IDLE.
REQ-025 GAP: no ready asserted; requests arriving in GAP SHALL be served from IDLE.
REQ-026 Latency: first MOSI bit is valid 1 cycle after acceptance; 16 cycles per word.
REQ-027 burst_done SHALL pulse in the cycle following bit_cnt==15 of a pix_last word.
REQ-028 tft_dc SHALL be forced to 1 for pixel-port words.

Reset
REQ-029 On reset low, the block SHALL immediately enter IDLE with tft_cs_n=1, tft_dc=0, word_data=0, bit_cnt=0, burst_lock=0, busy=0, burst_done=0, and both readies low.
REQ-030 Reset mid-word SHALL abort the transfer with no ready or burst_done pulse; on release the block starts in IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, word width 16, and DC_CMD=0 / DC_DATA=1 constants.
REQ-032 Arbitration (REQ-017/018/019) SHALL live in one sub-module, tft_spi_arb.

Verification
REQ-033 Single command 0x002A from IDLE -> cmd_ready 1 cycle; 16 cycles of cs_n=0, dc=0, bit_cnt 0..15; 2 GAP cycles; then IDLE.
REQ-034 Simultaneous cmd 0x002C and pixel 0xF800 with CMD_PRIORITY=1 -> command shifted first, pixel granted at its bit_cnt==15, cs_n never high in between.
REQ-035 Pixel burst 0x001F,0x07E0,0xF800 (last) with cmd_valid held high -> cmd_ready stays 0 until the third word is accepted; burst_done pulses once.
REQ-036 Burst stall: pix_valid drops 5 cycles after word 1 (pix_last=0) -> bit_cnt holds 15, cs_n stays 0, resume on next pix_valid.
REQ-037 reset low at bit_cnt==7 -> outputs match REQ-029 on the same cycle; no ready or burst_done pulse.

Source files
------------

// File: rtl/tft_spi_sched_pkg.sv
// Shared constants for the TFT SPI word scheduler: FSM encoding, word geometry, D/C levels.
package tft_spi_sched_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WORD_W - 1);

endpackage

// File: rtl/tft_spi_arb.sv
// Two-port word arbiter with pixel-burst lock; grants are combinational with the valids.
module tft_spi_arb #(
  parameter bit CMD_PRIORITY = 1'b1
) (
  input  logic SPI_CLK,
  input  logic reset,
  input  logic grant_en,
  input  logic cmd_valid,
  input  logic pix_valid,
  input  logic pix_last,
  output logic cmd_ready,
  output logic pix_ready,
  output logic burst_lock
);

  logic lock_q, lock_d;

  always_comb begin
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    if (grant_en) begin
      if (lock_q) begin
        // Inside a burst the command port is frozen out until the last pixel word.
        pix_ready = pix_valid;
      end else if (cmd_valid && pix_valid) begin
        cmd_ready = CMD_PRIORITY;
        pix_ready = !CMD_PRIORITY;
      end else begin
        cmd_ready = cmd_valid;
        pix_ready = pix_valid;
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (pix_ready) lock_d = !pix_last;
  end

  always_ff @(negedge SPI_CLK or negedge reset) begin
    if (!reset) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end

  assign burst_lock = lock_q;

endmodule

// File: rtl/tft_spi_sched.sv
// Schedules command and pixel words onto a TFT SPI serializer; all state moves on the
// falling SPI_CLK edge so the serializer can sample word_data/bit_cnt on the rising edge.
module tft_spi_sched
  import tft_spi_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CMD_PRIORITY = 1
) (
  input  logic              SPI_CLK,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [WORD_W-1:0] cmd_data,
  input  logic              cmd_dc,
  output logic              cmd_ready,
  input  logic              pix_valid,
  input  logic [WORD_W-1:0] pix_data,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic [WORD_W-1:0] word_data,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              tft_cs_n,
  output logic              tft_dc,
  output logic              busy,
  output logic              burst_done
);

  localparam logic [CNT_W-1:0] GapLoad = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  gap_q, gap_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              dc_q, dc_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              grant_en, accept, burst_lock;

  // Readies are gated by reset so nothing can be accepted while it is held low.
  assign grant_en = reset &&
                    ((state_q == StIdle) || ((state_q == StShift) && (cnt_q == LastBit)));
  assign accept   = cmd_ready || pix_ready;

  tft_spi_arb #(
    .CMD_PRIORITY (CMD_PRIORITY != 0)
  ) u_arb (
    .SPI_CLK    (SPI_CLK),
    .reset      (reset),
    .grant_en   (grant_en),
    .cmd_valid  (cmd_valid),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .cmd_ready  (cmd_ready),
    .pix_ready  (pix_ready),
    .burst_lock (burst_lock)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    word_d  = word_q;
    dc_d    = dc_q;
    last_d  = last_q;
    done_d  = (state_q == StShift) && (cnt_q == LastBit) && last_q;
    if (accept) begin
      state_d = StShift;
      cnt_d   = '0;
      word_d  = pix_ready ? pix_data : cmd_data;
      dc_d    = pix_ready ? DC_DATA : cmd_dc;
      last_d  = pix_ready && pix_last;
    end else begin
      case (state_q)
        StShift: begin
          if (cnt_q != LastBit) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!burst_lock) begin
            state_d = StGap;
            cnt_d   = '0;
            gap_d   = GapLoad;
          end
        end
        StGap: begin
          if (gap_q == '0) state_d = StIdle;
          else             gap_d   = gap_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge SPI_CLK or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      dc_q    <= DC_CMD;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      dc_q    <= dc_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign word_data  = word_q;
  assign bit_cnt    = cnt_q;
  assign tft_dc     = dc_q;
  assign tft_cs_n   = (state_q != StShift);
  assign busy       = (state_q != StIdle);
  assign burst_done = done_q;

endmodule

// File: tb/tb_tft_spi_sched.sv
// Scoreboard bench: driver predicts grants from the arbitration rules and queues expected
// words; a monitor checks control outputs every cycle and pops words as they start shifting.
module tb_tft_spi_sched;

  localparam int unsigned GAP  = 2;
  localparam int unsigned CMDP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_dc = 1'b0, pix_valid = 1'b0, pix_last = 1'b0;
  logic [15:0] cmd_data = '0, pix_data = '0;
  logic        cmd_ready, pix_ready, tft_cs_n, tft_dc, busy, burst_done;
  logic [15:0] word_data;
  logic [3:0]  bit_cnt;

  always #5 clk = ~clk;

  tft_spi_sched #(
    .GAP_CYCLES   (GAP),
    .CMD_PRIORITY (CMDP)
  ) dut (
    .SPI_CLK    (clk),
    .reset      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_dc     (cmd_dc),
    .cmd_ready  (cmd_ready),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .word_data  (word_data),
    .bit_cnt    (bit_cnt),
    .tft_cs_n   (tft_cs_n),
    .tft_dc     (tft_dc),
    .busy       (busy),
    .burst_done (burst_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in word (-1 = not shifting), gap cycles left, burst lock.
  int   m_pos  = -1;
  int   m_gap  = 0;
  bit   m_lock = 1'b0;
  bit   m_last = 1'b0;
  bit   m_done = 1'b0;
  logic e_cmd  = 1'b0;
  logic e_pix  = 1'b0;

  logic [16:0] exp_q[$];  // {dc, word} in expected shift order
  logic [16:0] cq[$];     // pending commands {dc, word}
  logic [16:0] pq[$];     // pending pixels {last, word}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_gap  = 0;
    m_lock = 1'b0;
    m_last = 1'b0;
    m_done = 1'b0;
    e_cmd  = 1'b0;
    e_pix  = 1'b0;
  endtask

  // One SPI_CLK cycle: present queue heads, predict the grant, then advance the model.
  task automatic step(input bit pen, input bit cen);
    bit          cv, pv, win;
    logic [16:0] c, p;
    @(posedge clk);
    cv = cen && (cq.size() > 0);
    pv = pen && (pq.size() > 0);
    c  = cv ? cq[0] : {1'b0, 16'($urandom)};
    p  = pv ? pq[0] : {1'b0, 16'($urandom)};
    cmd_valid = cv;
    cmd_data  = c[15:0];
    cmd_dc    = c[16];
    pix_valid = pv;
    pix_data  = p[15:0];
    pix_last  = p[16];
    win   = rst_n && (((m_pos < 0) && (m_gap == 0)) || (m_pos == 15));
    e_cmd = 1'b0;
    e_pix = 1'b0;
    if (win) begin
      if (m_lock)         e_pix = pv;
      else if (cv && pv)  begin e_cmd = (CMDP != 0); e_pix = (CMDP == 0); end
      else                begin e_cmd = cv; e_pix = pv; end
    end
    if (e_cmd) begin exp_q.push_back(c); void'(cq.pop_front()); end
    if (e_pix) begin exp_q.push_back({1'b1, p[15:0]}); void'(pq.pop_front()); end
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_done = (m_pos == 15) && m_last;
      if (e_cmd || e_pix) begin
        m_pos  = 0;
        m_gap  = 0;
        m_last = e_pix && p[16];
        if (e_pix) m_lock = !p[16];
      end else if (m_pos >= 0 && m_pos < 15) begin
        m_pos++;
      end else if (m_pos == 15) begin
        if (!m_lock) begin m_pos = -1; m_gap = GAP; end
      end else if (m_gap > 0) begin
        m_gap--;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (cq.size() == 0 && pq.size() == 0 && m_pos < 0 && m_gap == 0) break;
      step(1'b1, 1'b1);
    end
    repeat (3) step(1'b1, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},  32'(tft_cs_n), 32'd1);
    check({tag, "_dc"},    32'(tft_dc), 32'd0);
    check({tag, "_word"},  32'(word_data), 32'd0);
    check({tag, "_bit"},   32'(bit_cnt), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(burst_done), 32'd0);
    check({tag, "_crdy"},  32'(cmd_ready), 32'd0);
    check({tag, "_prdy"},  32'(pix_ready), 32'd0);
  endtask

  // Monitor
  initial begin
    logic [16:0] cur = '0;
    forever begin
      @(posedge clk);
      #1;
      check("cmd_ready",  32'(cmd_ready), 32'(e_cmd));
      check("pix_ready",  32'(pix_ready), 32'(e_pix));
      check("cs_n",       32'(tft_cs_n), 32'(m_pos < 0));
      check("bit_cnt",    32'(bit_cnt), (m_pos >= 0) ? m_pos : 0);
      check("busy",       32'(busy), 32'((m_pos >= 0) || (m_gap > 0)));
      check("burst_done", 32'(burst_done), 32'(m_done));
      if (tft_cs_n === 1'b0) begin
        if (bit_cnt == 4'd0) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_order: word %0h started, expected none", word_data);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        check("word_data", 32'(word_data), 32'(cur[15:0]));
        check("tft_dc",    32'(tft_dc), 32'(cur[16]));
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("rst0");
    repeat (2) step(1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Single command from idle, then gap and idle
    cq.push_back({1'b0, 16'h002A});
    drain();

    // Simultaneous command and pixel: command first, pixel back-to-back
    cq.push_back({1'b0, 16'h002C});
    pq.push_back({1'b1, 16'hF800});
    drain();

    // Pixel burst with a command waiting throughout
    pq.push_back({1'b0, 16'h001F});
    pq.push_back({1'b0, 16'h07E0});
    pq.push_back({1'b1, 16'hF800});
    cq.push_back({1'b1, 16'h00B0});
    step(1'b1, 1'b0);
    drain();

    // Burst stall: pixel valid drops after word 1, hold at bit 15, then resume
    pq.push_back({1'b0, 16'h1111});
    pq.push_back({1'b1, 16'h2222});
    step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    repeat (25) step(1'b0, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (cq.size() < 2 && $urandom_range(0, 9) == 0)
        cq.push_back({1'($urandom), 16'($urandom)});
      if (pq.size() < 2 && $urandom_range(0, 7) == 0) begin
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) pq.push_back({1'(k == len - 1), 16'($urandom)});
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    drain();

    // Reset in the middle of a word
    cq.push_back({1'b0, 16'h5A5A});
    step(1'b0, 1'b1);
    for (int i = 0; i < 40 && m_pos != 7; i++) step(1'b0, 1'b0);
    #1 check("pre_rst_bit", 32'(bit_cnt), 32'd7);
    #1 rst_n = 1'b0;
    cmd_valid = 1'b1;
    pix_valid = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    cq.push_back({1'b0, 16'h0029});
    pq.push_back({1'b1, 16'h7BEF});
    repeat (3) step(1'b1, 1'b1);
    #2 rst_n = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
